// File: rtl/vector_pkg.sv
// Shared definitions for the vector display-list sequencer.
// Contents: command word field positions, opcode encodings, sequencer FSM
// state encodings and a small opcode helper. Imported by the interface,
// the command decoder and the sequencer top.
package vector_pkg;

  localparam int unsigned CMD_W       = 32;
  localparam int unsigned CMD_OP_MSB  = 31;
  localparam int unsigned CMD_OP_LSB  = 30;
  localparam int unsigned CMD_X_MSB   = 29;  // x occupies [29 -: COORD_W]
  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    OP_MOVE = 2'b00,
    OP_DRAW = 2'b01,
    OP_HALT = 2'b10,
    OP_NOP  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_MEM = 3'd2,
    S_ISSUE    = 3'd3,
    S_SETTLE   = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  // MOVE and DRAW are the only commands that hand a target to the drawer.
  function automatic logic op_is_pulse(op_t op);
    return (op == OP_MOVE) || (op == OP_DRAW);
  endfunction

endpackage

// File: rtl/vector_list_sequencer_if.sv
// Bus bundle between the sequencer, its display-list memory and the
// line-drawer control block.
//   mem_addr/mem_rd : list read request (data returns one cycle later)
//   mem_rdata       : command word
//   x/y/draw/jump   : drawer target and one-cycle command pulses
//   ready           : drawer idle/accepting
// master = sequencer side, slave = memory/drawer side.
interface vector_list_sequencer_if
  import vector_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned COORD_W = 12
);
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd;
  logic [CMD_W-1:0]   mem_rdata;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               draw;
  logic               jump;
  logic               ready;

  modport master (
    output mem_addr, mem_rd, x, y, draw, jump,
    input  mem_rdata, ready
  );

  modport slave (
    input  mem_addr, mem_rd, x, y, draw, jump,
    output mem_rdata, ready
  );
endinterface

// File: rtl/vector_cmd_decode.sv
// Combinational display-list command decoder.
//   i_word : 32-bit command word
//   o_op   : opcode [31:30]
//   o_x    : x field [29 -: COORD_W]
//   o_y    : y field [COORD_W-1:0]
module vector_cmd_decode
  import vector_pkg::*;
#(
  parameter int unsigned COORD_W = 12
) (
  input  logic [CMD_W-1:0]   i_word,
  output op_t                o_op,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y
);
  // Bits between the x and y fields are reserved and intentionally ignored.
  logic w_unused_word;

  assign o_op          = op_t'(i_word[CMD_OP_MSB:CMD_OP_LSB]);
  assign o_x           = i_word[CMD_X_MSB -: COORD_W];
  assign o_y           = i_word[COORD_W-1:0];
  assign w_unused_word = ^i_word;
endmodule

// File: rtl/vector_list_sequencer.sv
// Vector display-list sequencer: walks a command list in memory and feeds
// MOVE/DRAW targets to the line drawer, one command at a time.
//   clk, reset  : clock, asynchronous active-high reset
//   start       : one-cycle pulse, begins a frame at address 0
//   stop        : level, ends the frame at the next command boundary
//   repeat_en   : restart at address 0 after HALT (repeat is a keyword)
//   busy        : high in every state except IDLE
//   frame_done  : one-cycle pulse when a frame completes
//   frame_count : completed frames, wraps at 16 bits
//   bus         : memory read port and drawer x/y/draw/jump/ready
module vector_list_sequencer
  import vector_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned COORD_W = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   repeat_en,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  vector_list_sequencer_if.master bus
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDR_W-1:0]      r_addr;
  logic [ADDR_W-1:0]      w_addr_nxt;
  logic [CMD_W-1:0]       r_cmd;
  logic [COORD_W-1:0]     r_x;
  logic [COORD_W-1:0]     r_y;
  logic                   r_draw;
  logic                   r_jump;
  logic                   r_frame_done;
  logic [FRAME_CNT_W-1:0] r_frame_count;

  logic                   w_mem_rd;
  logic                   w_cmd_load;
  logic                   w_issue;
  logic                   w_done;
  logic                   w_last_addr;
  op_t                    w_op;
  logic [COORD_W-1:0]     w_x;
  logic [COORD_W-1:0]     w_y;

  vector_cmd_decode #(.COORD_W(COORD_W)) u_decode (
    .i_word (r_cmd),
    .o_op   (w_op),
    .o_x    (w_x),
    .o_y    (w_y)
  );

  // Stepping past the top of the list ends the frame instead of wrapping.
  assign w_last_addr = &r_addr;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_mem_rd    = 1'b0;
    w_cmd_load  = 1'b0;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
          w_addr_nxt  = '0;
        end
      end
      S_FETCH: begin
        if (stop) begin
          w_state_nxt = S_DONE;
        end else begin
          w_mem_rd    = 1'b1;
          w_state_nxt = S_WAIT_MEM;
        end
      end
      S_WAIT_MEM: begin
        w_cmd_load  = 1'b1;
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (op_is_pulse(w_op)) begin
          if (bus.ready) begin
            w_issue     = 1'b1;
            w_state_nxt = S_SETTLE;
          end
        end else if (w_op == OP_NOP) begin
          if (w_last_addr) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_FETCH;
            w_addr_nxt  = r_addr + ADDR_W'(1);
          end
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_SETTLE: begin
        if (w_last_addr) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_FETCH;
          w_addr_nxt  = r_addr + ADDR_W'(1);
        end
      end
      S_DONE: begin
        if (bus.ready) begin
          w_done = 1'b1;
          if (repeat_en && !stop) begin
            w_state_nxt = S_FETCH;
            w_addr_nxt  = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr        <= '0;
      r_cmd         <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_draw        <= 1'b0;
      r_jump        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_addr <= w_addr_nxt;
      if (w_cmd_load) begin
        r_cmd <= bus.mem_rdata;
      end
      // Target and pulse register together so the drawer sees them in the same cycle.
      if (w_issue) begin
        r_x <= w_x;
        r_y <= w_y;
      end
      r_draw       <= w_issue && (w_op == OP_DRAW);
      r_jump       <= w_issue && (w_op == OP_MOVE);
      r_frame_done <= w_done;
      if (w_done) begin
        r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
      end
    end
  end

  assign bus.mem_addr = r_addr;
  assign bus.mem_rd   = w_mem_rd;
  assign bus.x        = r_x;
  assign bus.y        = r_y;
  assign bus.draw     = r_draw;
  assign bus.jump     = r_jump;
  assign busy         = (r_state != S_IDLE);
  assign frame_done   = r_frame_done;
  assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_vector_list_sequencer.sv
module tb_vector_list_sequencer;
  import vector_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned CW = 12;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        start     = 1'b0;
  logic        stop      = 1'b0;
  logic        repeat_en = 1'b0;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;

  vector_list_sequencer_if #(.ADDR_W(AW), .COORD_W(CW)) bus ();

  vector_list_sequencer #(.ADDR_W(AW), .COORD_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .repeat_en   (repeat_en),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Display-list memory: one-cycle read latency.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int          tests = 0;
  int          fails = 0;
  int unsigned exp_frames = 0;
  int unsigned rd_cnt = 0;
  int unsigned rd0_cnt = 0;
  int unsigned done_cnt = 0;

  // kind: 0 jump, 1 draw, 2 frame_done
  typedef struct {
    int          kind;
    logic [11:0] x;
    logic [11:0] y;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    op_t         op;
    logic [11:0] x;
    logic [11:0] y;
    int          kind;   // 3 = no drawer pulse expected
    logic [11:0] ex;
    logic [11:0] ey;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] op, input logic [11:0] x, input logic [11:0] y);
    return {op, x, 6'b101101, y};
  endfunction

  task automatic push(input int kind, input logic [11:0] x, input logic [11:0] y);
    sb_t e;
    e.kind = kind;
    e.x    = x;
    e.y    = y;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_frame(input int unsigned bound);
    int unsigned n;
    n = 0;
    while (busy && n < bound) begin
      step();
      n++;
    end
    check("frame_end_timeout", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("frame_count", 32'(frame_count), 32'(exp_frames[15:0]));
  endtask

  task automatic wait_jump();
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.jump && n < 50);
    check("jump_seen", 32'(bus.jump), 32'd1);
  endtask

  // Scoreboard monitor: every drawer pulse and frame_done must match the queue head.
  always @(negedge clk) begin
    sb_t e;
    int  k;
    if (bus.mem_rd) begin
      rd_cnt++;
      if (bus.mem_addr == '0) rd0_cnt++;
    end
    if (frame_done) done_cnt++;
    if (bus.draw || bus.jump || frame_done) begin
      k = bus.draw ? 1 : (bus.jump ? 0 : 2);
      if (bus.draw || bus.jump) check("draw_jump_excl", 32'(bus.draw & bus.jump), 32'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got event kind %0d, expected none", k);
      end else begin
        e = sb.pop_front();
        check("sb_kind", 32'(k), 32'(e.kind));
        if (k != 2) begin
          check("sb_x", 32'(bus.x), 32'(e.x));
          check("sb_y", 32'(bus.y), 32'(e.y));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  int unsigned base, base0, nd, n, bad_pulse, bad_xy;

  initial begin
    tbl[0] = '{OP_MOVE, 12'h000, 12'h000, 0, 12'h000, 12'h000};
    tbl[1] = '{OP_DRAW, 12'hFFF, 12'hFFF, 1, 12'hFFF, 12'hFFF};
    tbl[2] = '{OP_NOP,  12'h123, 12'h456, 3, 12'hFFF, 12'hFFF};
    tbl[3] = '{OP_MOVE, 12'hFFF, 12'h000, 0, 12'hFFF, 12'h000};
    tbl[4] = '{OP_HALT, 12'h777, 12'h777, 3, 12'hFFF, 12'h000};
    tbl[5] = '{OP_DRAW, 12'h000, 12'hFFF, 1, 12'h000, 12'hFFF};
    tbl[6] = '{OP_DRAW, 12'hABC, 12'h123, 1, 12'hABC, 12'h123};
    for (int i = 0; i < 1024; i++) mem[i] = mk(OP_HALT, 12'h0, 12'h0);
    bus.ready = 1'b1;

    // Reset state
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_xy", {8'd0, bus.x, bus.y}, 32'd0);
    check("rst_pulses", {29'd0, bus.draw, bus.jump, frame_done}, 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // Basic list: MOVE, DRAW, HALT
    mem[0] = mk(OP_MOVE, 12'd5, 12'd10);
    mem[1] = mk(OP_DRAW, 12'd100, 12'd200);
    mem[2] = mk(OP_HALT, 12'd0, 12'd0);
    push(0, 12'd5, 12'd10);
    push(1, 12'd100, 12'd200);
    push(2, 12'd0, 12'd0);
    exp_frames++;
    pulse_start();
    finish_frame(100);
    check("basic_idle", 32'(busy), 32'd0);

    // Single-command frames from the table
    for (int i = 0; i < 7; i++) begin
      mem[0] = mk(tbl[i].op, tbl[i].x, tbl[i].y);
      mem[1] = mk(OP_HALT, 12'd0, 12'd0);
      if (tbl[i].kind != 3) push(tbl[i].kind, tbl[i].ex, tbl[i].ey);
      push(2, 12'd0, 12'd0);
      exp_frames++;
      pulse_start();
      finish_frame(100);
      check("vec_x", 32'(bus.x), 32'(tbl[i].ex));
      check("vec_y", 32'(bus.y), 32'(tbl[i].ey));
    end

    // Drawer stall: ready low through ISSUE of a DRAW
    mem[0] = mk(OP_MOVE, 12'd7, 12'd9);
    mem[1] = mk(OP_DRAW, 12'd300, 12'd400);
    mem[2] = mk(OP_HALT, 12'd0, 12'd0);
    push(0, 12'd7, 12'd9);
    push(1, 12'd300, 12'd400);
    push(2, 12'd0, 12'd0);
    exp_frames++;
    pulse_start();
    wait_jump();
    #1 bus.ready = 1'b0;
    repeat (3) @(negedge clk);
    bad_pulse = 0;
    bad_xy = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.draw || bus.jump) bad_pulse++;
      if (bus.x != 12'd7 || bus.y != 12'd9) bad_xy++;
    end
    check("stall_no_pulse", bad_pulse, 32'd0);
    check("stall_xy_stable", bad_xy, 32'd0);
    #1 bus.ready = 1'b1;
    @(negedge clk);
    check("stall_release_draw", 32'(bus.draw), 32'd1);
    check("stall_release_x", 32'(bus.x), 32'd300);
    finish_frame(100);

    // Repeat mode over a 3-entry list
    mem[0] = mk(OP_MOVE, 12'd1, 12'd2);
    mem[1] = mk(OP_DRAW, 12'd3, 12'd4);
    mem[2] = mk(OP_HALT, 12'd0, 12'd0);
    for (int f = 0; f < 3; f++) begin
      push(0, 12'd1, 12'd2);
      push(1, 12'd3, 12'd4);
      push(2, 12'd0, 12'd0);
    end
    exp_frames += 3;
    repeat_en = 1'b1;
    pulse_start();
    nd = 0;
    n = 0;
    while (nd < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (frame_done) nd++;
    end
    check("rep_frames_seen", nd, 32'd3);
    check("rep_busy", 32'(busy), 32'd1);
    check("rep_addr_zero", 32'(bus.mem_addr), 32'd0);
    check("rep_refetch", 32'(bus.mem_rd), 32'd1);
    check("rep_frame_count", 32'(frame_count), 32'(exp_frames[15:0]));
    #1 repeat_en = 1'b0;
    push(0, 12'd1, 12'd2);
    push(1, 12'd3, 12'd4);
    push(2, 12'd0, 12'd0);
    exp_frames++;
    finish_frame(100);

    // Stop raised while a DRAW waits to issue
    mem[0] = mk(OP_MOVE, 12'd10, 12'd20);
    mem[1] = mk(OP_DRAW, 12'd30, 12'd40);
    mem[2] = mk(OP_DRAW, 12'd50, 12'd60);
    mem[3] = mk(OP_HALT, 12'd0, 12'd0);
    push(0, 12'd10, 12'd20);
    push(1, 12'd30, 12'd40);
    push(2, 12'd0, 12'd0);
    exp_frames++;
    pulse_start();
    wait_jump();
    #1 bus.ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 stop = 1'b1;
    base = rd_cnt;
    base0 = done_cnt;
    repeat (4) @(negedge clk);
    #1 bus.ready = 1'b1;
    finish_frame(100);
    repeat (5) step();
    check("stop_no_rd", rd_cnt - base, 32'd0);
    check("stop_one_done", done_cnt - base0, 32'd1);
    stop = 1'b0;

    // Full list with no HALT ends at the top address
    for (int i = 0; i < 1024; i++) mem[i] = mk(OP_NOP, 12'(i), 12'(i));
    mem[0]    = mk(OP_MOVE, 12'd1, 12'd1);
    mem[1023] = mk(OP_DRAW, 12'd2, 12'd2);
    push(0, 12'd1, 12'd1);
    push(1, 12'd2, 12'd2);
    push(2, 12'd0, 12'd0);
    exp_frames++;
    base = rd_cnt;
    base0 = rd0_cnt;
    pulse_start();
    finish_frame(5000);
    check("full_end_addr", 32'(bus.mem_addr), 32'd1023);
    check("full_rd_count", rd_cnt - base, 32'd1024);
    check("full_no_wrap", rd0_cnt - base0, 32'd1);

    // Reset while the MOVE settles
    mem[0] = mk(OP_NOP, 12'd0, 12'd0);
    mem[1] = mk(OP_MOVE, 12'd11, 12'd22);
    mem[2] = mk(OP_DRAW, 12'd33, 12'd44);
    mem[3] = mk(OP_HALT, 12'd0, 12'd0);
    push(0, 12'd11, 12'd22);
    pulse_start();
    wait_jump();
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("arst_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("arst_xy", {8'd0, bus.x, bus.y}, 32'd0);
    check("arst_pulses", {29'd0, bus.draw, bus.jump, frame_done}, 32'd0);
    check("arst_frame_count", 32'(frame_count), 32'd0);
    sb.delete();
    exp_frames = 0;
    step();
    step();
    reset = 1'b0;
    base = rd_cnt;
    repeat (5) step();
    check("arst_stays_idle", 32'(busy), 32'd0);
    check("arst_no_rd", rd_cnt - base, 32'd0);
    push(0, 12'd11, 12'd22);
    push(1, 12'd33, 12'd44);
    push(2, 12'd0, 12'd0);
    exp_frames++;
    pulse_start();
    finish_frame(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
